trace_buffer: RTL and testbench

Parametrised execution-trace capture block that sits beside `cpu_top` and records one entry per retired instruction: pc, instruction word and ALU result. Entries go into a circular buffer. Capture runs in one of three modes: free-running, stop-after-N, or pc-triggered with pre/post history. When capture completes, the block asserts a CPU halt request and drains its entries oldest-first over a valid/ready port. This replaces ad-hoc per-cycle printing with a reusable, synthesizable debug record.

---
 rtl/trace_pkg.sv | 32 +++
 rtl/trace_ram.sv | 31 +++
 rtl/trace_buffer.sv | 136 +++++++++++++
 tb/tb_trace_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the execution-trace buffer: FSM states, capture modes and entry layout.
package trace_pkg;

    localparam int TRACE_XLEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_POST    = 3'd2,
        ST_DONE    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_FREE  = 2'd0;
    localparam logic [1:0] MODE_COUNT = 2'd1;
    localparam logic [1:0] MODE_TRIG  = 2'd2;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           inst;
        logic [TRACE_XLEN-1:0] result;
    } trace_entry_t;

    // A zero count means a full buffer; COUNT limits above DEPTH are clamped so they never overwrite.
    function automatic int unsigned eff_count(input int unsigned cfg, input int unsigned depth,
                                              input logic clamp);
        if (cfg == 0) return depth;
        if (clamp && cfg > depth) return depth;
        return cfg;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port entry store: synchronous write, registered read, no reset on the array.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 96
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_buffer.sv
// Retired-instruction trace capture (FREE / COUNT / TRIG) with halt request and oldest-first drain.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN  = TRACE_XLEN,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            retire_valid,
    input  logic [XLEN-1:0] retire_pc,
    input  logic [31:0]     retire_inst,
    input  logic [XLEN-1:0] retire_result,
    input  logic [1:0]      cfg_mode,
    input  logic [AW:0]     cfg_count,
    input  logic [XLEN-1:0] cfg_trig_pc,
    input  logic            arm,
    input  logic            stop,
    output logic            halt_req,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [XLEN-1:0] rd_pc,
    output logic [31:0]     rd_inst,
    output logic [XLEN-1:0] rd_result,
    output logic [AW:0]     fill,
    output logic            overflow,
    output logic [2:0]      state
);

    localparam int CW = AW + 1;
    localparam int EW = 2 * XLEN + 32;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t          r_state, w_next;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_base, w_raddr;
    logic [CW-1:0]   r_fill, r_count, r_post_cnt, w_fill_inc;
    logic            r_overflow;
    logic [1:0]      r_mode, w_cfg_mode;
    logic [XLEN-1:0] r_trig_pc;
    logic            w_wr_en, w_hs, w_re, w_trig_hit, w_count_hit, w_post_end;
    logic [EW-1:0]   w_rdata;

    assign w_wr_en     = (r_state == ST_CAPTURE || r_state == ST_POST) && retire_valid && !arm;
    assign w_hs        = rd_valid && rd_ready;
    assign w_fill_inc  = r_fill + 1'b1;
    assign w_trig_hit  = (r_state == ST_CAPTURE) && (r_mode == MODE_TRIG) && (retire_pc == r_trig_pc);
    assign w_count_hit = (r_mode == MODE_COUNT) && (w_fill_inc == r_count);
    assign w_post_end  = (r_state == ST_POST) && (r_post_cnt == CW'(1));
    assign w_cfg_mode  = (cfg_mode == MODE_COUNT || cfg_mode == MODE_TRIG) ? cfg_mode : MODE_FREE;
    assign w_rd_base   = r_wr_ptr - r_fill[AW-1:0];

    // Prefetch the oldest entry during DONE so data is ready the cycle DRAIN starts.
    assign w_re    = (r_state == ST_DONE) || w_hs;
    assign w_raddr = (r_state == ST_DONE) ? w_rd_base : (w_hs ? r_rd_ptr + 1'b1 : r_rd_ptr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (arm) begin
            w_next = ST_CAPTURE;
        end else begin
            case (r_state)
                ST_CAPTURE: begin
                    if (w_wr_en && w_count_hit)     w_next = ST_DONE;
                    else if (w_wr_en && w_trig_hit) w_next = ST_POST;
                    if (stop)                       w_next = ST_DONE;
                end
                ST_POST:  if (stop || (w_wr_en && w_post_end)) w_next = ST_DONE;
                ST_DONE:  w_next = ST_DRAIN;
                ST_DRAIN: if (r_fill == '0 || (w_hs && r_fill == CW'(1))) w_next = ST_IDLE;
                default:  w_next = r_state;
            endcase
        end
    end

    always_comb begin
        halt_req = (r_state == ST_DONE) || (r_state == ST_DRAIN);
        rd_valid = (r_state == ST_DRAIN) && (r_fill != '0);
        state    = r_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
            r_mode     <= MODE_FREE;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_trig_pc  <= '0;
        end else if (arm) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
            r_mode     <= w_cfg_mode;
            r_count    <= CW'(eff_count(32'(cfg_count), DEPTH, w_cfg_mode == MODE_COUNT));
            r_trig_pc  <= cfg_trig_pc;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_fill == FULL) r_overflow <= 1'b1;
                else                r_fill     <= w_fill_inc;
                if (w_trig_hit)                r_post_cnt <= r_count;
                else if (r_state == ST_POST)   r_post_cnt <= r_post_cnt - 1'b1;
            end
            if (r_state == ST_DONE) r_rd_ptr <= w_rd_base;
            if (w_hs) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_fill   <= r_fill - 1'b1;
            end
        end
    end

    trace_ram #(.DEPTH(DEPTH), .AW(AW), .W(EW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata ({retire_pc, retire_inst, retire_result}),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign {rd_pc, rd_inst, rd_result} = w_rdata;
    assign fill     = r_fill;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed and randomized checks of trace_buffer against a queue-based capture/drain model.
module tb_trace_buffer;
    import trace_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic            clk = 1'b0, rst = 1'b0;
    logic            retire_valid = 1'b0;
    logic [XLEN-1:0] retire_pc = '0, retire_result = '0;
    logic [31:0]     retire_inst = '0;
    logic [1:0]      cfg_mode = '0;
    logic [AW:0]     cfg_count = '0;
    logic [XLEN-1:0] cfg_trig_pc = '0;
    logic            arm = 1'b0, stop = 1'b0, rd_ready = 1'b0;
    logic            halt_req, rd_valid, overflow;
    logic [XLEN-1:0] rd_pc, rd_result;
    logic [31:0]     rd_inst;
    logic [AW:0]     fill;
    logic [2:0]      state;

    trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_inst(retire_inst), .retire_result(retire_result), .cfg_mode(cfg_mode),
        .cfg_count(cfg_count), .cfg_trig_pc(cfg_trig_pc), .arm(arm), .stop(stop),
        .halt_req(halt_req), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
        .rd_inst(rd_inst), .rd_result(rd_result), .fill(fill), .overflow(overflow),
        .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: the buffer is a queue of the most recent DEPTH records.
    trace_entry_t    q[$];
    bit              m_active, m_in_post, m_ovf;
    int              m_mode, m_cnt, m_post_left;
    logic [XLEN-1:0] m_trig;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rdy(input int pat, input int cyc);
        case (pat)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return ((cyc % 4) == 3) || ($urandom_range(0, 1) == 1);
        endcase
    endfunction

    task automatic model_edge(input bit v, input logic [XLEN-1:0] pc, input logic [31:0] inst,
                              input logic [XLEN-1:0] res, input bit st);
        trace_entry_t e;
        if (!m_active) return;
        if (v) begin
            e.pc = pc; e.inst = inst; e.result = res;
            q.push_back(e);
            if (q.size() > DEPTH) begin
                void'(q.pop_front());
                m_ovf = 1'b1;
            end
            if (m_mode == 1 && q.size() == m_cnt) m_active = 1'b0;
            if (m_mode == 2) begin
                if (m_in_post) begin
                    m_post_left--;
                    if (m_post_left == 0) m_active = 1'b0;
                end else if (pc == m_trig) begin
                    m_in_post   = 1'b1;
                    m_post_left = m_cnt;
                end
            end
        end
        if (st) m_active = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] mode, input int cnt, input logic [XLEN-1:0] trig,
                          input bit with_stop);
        arm = 1'b1; stop = with_stop;
        cfg_mode = mode; cfg_count = (AW+1)'(cnt); cfg_trig_pc = trig;
        retire_valid = 1'($urandom_range(0, 1));
        tick();
        arm = 1'b0; stop = 1'b0; retire_valid = 1'b0;
        q.delete();
        m_ovf = 1'b0; m_active = 1'b1; m_in_post = 1'b0; m_post_left = 0;
        m_mode = (mode == 2'd3) ? 0 : int'(mode);
        m_cnt  = (cnt == 0) ? DEPTH : cnt;
        m_trig = trig;
        chk("arm_state", state, ST_CAPTURE);
        chk("arm_fill", fill, 0);
        chk("arm_overflow", overflow, 0);
        chk("arm_halt", halt_req, 0);
    endtask

    task automatic capture(input int n_ret, input bit rnd, input int stop_at, input int exp_fill);
        bit v;
        logic [XLEN-1:0] pc;
        for (int i = 0; i < n_ret && m_active; i++) begin
            v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            pc = rnd ? XLEN'(4 * $urandom_range(0, 15)) : XLEN'(4 * i);
            retire_valid = v; retire_pc = pc;
            retire_inst = $urandom; retire_result = $urandom;
            stop = (i == stop_at);
            model_edge(v, pc, retire_inst, retire_result, stop);
            tick();
            retire_valid = 1'b0; stop = 1'b0;
            if (!m_active) break;
            chk("cap_state", state, m_in_post ? ST_POST : ST_CAPTURE);
            chk("cap_fill", fill, q.size());
            chk("cap_overflow", overflow, m_ovf);
            chk("cap_halt", halt_req, 0);
        end
        if (m_active) begin
            stop = 1'b1;
            model_edge(1'b0, '0, '0, '0, 1'b1);
            tick();
            stop = 1'b0;
        end
        chk("done_state", state, ST_DONE);
        chk("done_halt", halt_req, 1);
        chk("done_rd_valid", rd_valid, 0);
        chk("done_fill", fill, q.size());
        chk("done_overflow", overflow, m_ovf);
        if (exp_fill >= 0) chk("done_fill_exp", fill, exp_fill);
    endtask

    // arm_after > 0 re-arms in FREE mode once that many entries have been accepted.
    task automatic drain(input int pat, input int arm_after);
        int n, idx;
        n = q.size(); idx = 0;
        rd_ready = 1'b1; retire_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
        if (n == 0) begin
            chk("empty_state", state, ST_DRAIN);
            chk("empty_rd_valid", rd_valid, 0);
            chk("empty_halt", halt_req, 1);
            tick();
        end else begin
            for (int cyc = 0; cyc < 4 * n + 10; cyc++) begin
                if (idx == n) break;
                if (arm_after > 0 && idx == arm_after) begin
                    rd_ready = 1'b0;
                    do_arm(2'd0, 0, '0, 1'b0);
                    return;
                end
                chk("drain_valid", rd_valid, 1);
                chk("drain_pc", rd_pc, q[idx].pc);
                chk("drain_inst", rd_inst, q[idx].inst);
                chk("drain_result", rd_result, q[idx].result);
                chk("drain_fill", fill, n - idx);
                chk("drain_halt", halt_req, 1);
                rd_ready = rdy(pat, cyc);
                retire_valid = 1'($urandom_range(0, 1));
                retire_pc = XLEN'(4 * $urandom_range(0, 15));
                stop = 1'($urandom_range(0, 1));
                if (rd_ready) idx++;
                tick();
            end
            chk("drain_count", idx, n);
        end
        rd_ready = 1'b0; retire_valid = 1'b0; stop = 1'b0;
        chk("end_state", state, ST_IDLE);
        chk("end_halt", halt_req, 0);
        chk("end_rd_valid", rd_valid, 0);
        chk("end_fill", fill, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int stop_at;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, ST_IDLE);
        chk("rst_halt", halt_req, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_pc", rd_pc, 0);
        rst = 1'b1;
        tick();
        chk("idle_state", state, ST_IDLE);

        // COUNT=5 over pc 0..28: stops after pc 16
        do_arm(2'd1, 5, '0, 1'b0);
        capture(8, 1'b0, -1, 5);
        chk("count_last_pc", q[q.size()-1].pc, 16);
        drain(0, 0);

        // FREE with 20 retires then stop: wraps, keeps pc 16..76
        do_arm(2'd0, 0, '0, 1'b0);
        capture(20, 1'b0, -1, DEPTH);
        chk("free_overflow", overflow, 1);
        chk("free_first_pc", q[0].pc, 16);
        drain(0, 0);

        // TRIG at pc 40 with 2 post records, stalled drain 1,0,0
        do_arm(2'd2, 2, 40, 1'b0);
        capture(16, 1'b0, -1, 13);
        chk("trig_last_pc", q[q.size()-1].pc, 48);
        drain(1, 0);

        // stop coincident with a retire records it first
        do_arm(2'd0, 0, '0, 1'b0);
        capture(5, 1'b0, 3, 4);
        drain(2, 0);

        // immediate stop: DONE with nothing held
        do_arm(2'd0, 0, '0, 1'b0);
        capture(0, 1'b0, -1, 0);
        drain(0, 0);

        // COUNT with count 0 means DEPTH, no overflow
        do_arm(2'd1, 0, '0, 1'b0);
        capture(20, 1'b0, -1, DEPTH);
        chk("count_full_ovf", overflow, 0);
        drain(0, 0);

        // reserved mode behaves as FREE
        do_arm(2'd3, 5, 8, 1'b0);
        capture(7, 1'b0, -1, 7);
        drain(0, 0);

        // arm and stop together: arm wins
        do_arm(2'd0, 0, '0, 1'b1);
        capture(2, 1'b0, -1, 2);
        drain(2, 0);

        // arm mid-drain, then reset mid-capture
        do_arm(2'd1, 6, '0, 1'b0);
        capture(10, 1'b0, -1, 6);
        drain(0, 2);
        for (int i = 0; i < 18; i++) begin
            retire_valid = 1'b1; retire_pc = XLEN'(4 * i);
            retire_inst = $urandom; retire_result = $urandom;
            model_edge(1'b1, retire_pc, retire_inst, retire_result, 1'b0);
            tick();
        end
        retire_valid = 1'b0;
        chk("pre_rst_fill", fill, q.size());
        chk("pre_rst_overflow", overflow, 1);
        rst = 1'b0;
        #1;
        chk("arst_state", state, ST_IDLE);
        chk("arst_halt", halt_req, 0);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_fill", fill, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_rd_pc", rd_pc, 0);
        chk("arst_rd_inst", rd_inst, 0);
        chk("arst_rd_result", rd_result, 0);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_state", state, ST_IDLE);

        // randomized sessions
        for (int s = 0; s < 25; s++) begin
            stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
            do_arm(2'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH)),
                   XLEN'(4 * $urandom_range(0, 15)), 1'b0);
            capture(int'($urandom_range(0, 40)), 1'b1, stop_at, -1);
            drain(int'($urandom_range(0, 2)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
